// File: rtl/pc_fetch_sequencer.sv
// Fetch/execute sequencer for the 32-bit MIPS core.
// Owns the architectural PC and retired counter and handles stall, halt and fetch timeout.
module pc_fetch_sequencer #(
    parameter int unsigned PC_W     = 14,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    output logic             imem_req_o,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             exec_done_i,
    input  logic             stall_i,
    input  logic             halt_i,
    input  logic [PC_W-1:0]  new_pc_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [CNT_W-1:0] retired_o,
    output logic             halted_o,
    output logic             fetch_err_o
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RST_WAIT,
        ST_FETCH,
        ST_EXEC,
        ST_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              halted_q, halted_d;
    logic              fetchErr_q, fetchErr_d;
    logic [TO_W-1:0]   toCnt_q, toCnt_d;

    // An ack arriving on the last allowed cycle is taken, so the timeout
    // fires only when the cycle that would reach TIMEOUT also lacks an ack.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        retired_d     = retired_q;
        halted_d      = halted_q;
        fetchErr_d    = fetchErr_q;
        toCnt_d       = toCnt_q;
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;

        case (state_q)
            ST_RST_WAIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = ST_EXEC;
                end else if (toCnt_q == TO_LAST) begin
                    toCnt_d    = TO_MAX;
                    fetchErr_d = 1'b1;
                    halted_d   = 1'b1;
                    state_d    = ST_HALT;
                end else begin
                    toCnt_d = toCnt_q + TO_W'(1);
                end
            end
            ST_EXEC: begin
                instr_valid_o = 1'b1;
                if (exec_done_i && !stall_i) begin
                    retired_d = retired_q + CNT_W'(1);
                    if (halt_i) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d    = new_pc_i;
                        toCnt_d = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_RST_WAIT;
            pc_q       <= PC_W'(RESET_PC);
            instr_q    <= '0;
            retired_q  <= '0;
            halted_q   <= 1'b0;
            fetchErr_q <= 1'b0;
            toCnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            retired_q  <= retired_d;
            halted_q   <= halted_d;
            fetchErr_q <= fetchErr_d;
            toCnt_q    <= toCnt_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign retired_o   = retired_q;
    assign halted_o    = halted_q;
    assign fetch_err_o = fetchErr_q;

endmodule
